// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin sharing of one single-ported, fixed-latency memory between
//   the instruction-fetch port (i_*) and the load/store port (d_*).
//
//   Handshake: a requester raises req with stable payload and holds it until
//   the cycle in which its gnt is 1. gnt is combinational. A grant in cycle T
//   puts the access on the memory port in cycle T and produces a one-cycle
//   valid strobe (with data) in cycle T+LAT+1. Responses have no back-pressure.
//
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     i_req, i_addr, i_flush     fetch request / address / kill in-flight fetches
//     i_gnt, i_valid, i_rdata    fetch grant / response strobe / response data
//     d_req, d_we, d_addr,
//     d_wdata                    data request, store flag, address, store data
//     d_gnt, d_valid, d_rdata    data grant / response strobe / load data (0 for stores)
//     m_en, m_we, m_addr,
//     m_wdata, m_rdata           memory port; m_rdata valid LAT cycles after m_en
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_gnt,
  output logic          i_valid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   we;
    logic   kill;
  } tag_t;

  // Owner of the most recent grant; the other port wins the next tie.
  owner_e last_q;

  // tag_q[k] holds the tag of the access issued k cycles ago. Age 0 is the
  // issue cycle itself (issue_tag); age LAT is the cycle m_rdata is valid.
  tag_t tag_q [1:LAT];
  tag_t aged  [1:LAT];
  tag_t issue_tag;

  logic i_elig;
  logic d_elig;

  always_comb begin
    i_elig = i_req & ~i_flush & ~reset;
    d_elig = d_req & ~reset;

    i_gnt = i_elig & (~d_elig | (last_q == OWN_D));
    d_gnt = d_elig & ~i_gnt;

    m_en    = i_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (i_gnt) begin
      m_addr = i_addr;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end

    issue_tag       = '0;
    issue_tag.valid = m_en;
    issue_tag.owner = d_gnt ? OWN_D : OWN_I;
    issue_tag.we    = m_we;

    // A flush marks every in-flight fetch, including the one whose data is
    // on m_rdata right now, so that it never reaches i_valid.
    for (int k = 1; k <= LAT; k++) begin
      aged[k]      = tag_q[k];
      aged[k].kill = tag_q[k].kill |
                     (i_flush & tag_q[k].valid & (tag_q[k].owner == OWN_I));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= OWN_D;
      for (int k = 1; k <= LAT; k++) tag_q[k] <= '0;
      i_valid <= 1'b0;
      i_rdata <= '0;
      d_valid <= 1'b0;
      d_rdata <= '0;
    end else begin
      if (m_en) last_q <= issue_tag.owner;

      tag_q[1] <= issue_tag;
      for (int k = 2; k <= LAT; k++) tag_q[k] <= aged[k-1];

      i_valid <= aged[LAT].valid & (aged[LAT].owner == OWN_I) & ~aged[LAT].kill;
      if (aged[LAT].valid & (aged[LAT].owner == OWN_I) & ~aged[LAT].kill)
        i_rdata <= m_rdata;

      d_valid <= aged[LAT].valid & (aged[LAT].owner == OWN_D);
      if (aged[LAT].valid & (aged[LAT].owner == OWN_D))
        d_rdata <= aged[LAT].we ? '0 : m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_flush, i_gnt, i_valid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- memory emulator (16 words, LAT-cycle read) ----------------
  logic [DW-1:0] mem    [16];
  logic [DW-1:0] rd_pipe[LAT];
  assign m_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[3:0]] <= m_wdata;
    rd_pipe[0] <= (m_en && !m_we) ? mem[m_addr[3:0]] : 32'hdeadbeef;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;
  req_t iq[$];
  req_t dq[$];

  task automatic push_i(input logic [AW-1:0] a);
    req_t r;
    r.addr = a; r.we = 1'b0; r.wdata = '0;
    iq.push_back(r);
  endtask

  task automatic push_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.wdata = wd;
    dq.push_back(r);
  endtask

  task automatic present();
    i_req   = iq.size() > 0;
    i_addr  = i_req ? iq[0].addr : '0;
    d_req   = dq.size() > 0;
    d_we    = d_req ? dq[0].we : 1'b0;
    d_addr  = d_req ? dq[0].addr : '0;
    d_wdata = d_req ? dq[0].wdata : '0;
  endtask

  // Advance one cycle; a request granted in the finished cycle is retired.
  task automatic tick();
    logic i_took, d_took;
    @(negedge clk);
    i_took = i_gnt;
    d_took = d_gnt;
    @(posedge clk);
    #1;
    if (i_took && iq.size() > 0) void'(iq.pop_front());
    if (d_took && dq.size() > 0) void'(dq.pop_front());
    present();
  endtask

  // ---------------- reference model + scoreboard producer ----------------
  typedef struct packed {
    int            due;
    logic          is_d;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  logic [DW-1:0] ref_mem[16];
  logic          ref_last_d = 1'b1;

  always @(negedge clk) begin
    logic ei, ed, gi, gd;
    ei = i_req & ~i_flush & ~reset;
    ed = d_req & ~reset;
    gi = ei & (!ed || ref_last_d);
    gd = ed & !gi;

    check("i_gnt", i_gnt, gi);
    check("d_gnt", d_gnt, gd);
    check("m_en", m_en, gi | gd);
    check("m_we", m_we, gd & d_we);
    check("m_addr", m_addr, gi ? i_addr : (gd ? d_addr : '0));
    if (!gi) check("m_wdata", m_wdata, gd ? d_wdata : '0);

    if (reset) begin
      ref_last_d = 1'b1;
      for (int k = exp_q.size() - 1; k >= 0; k--)
        if (exp_q[k].due > cyc) exp_q.delete(k);
    end else begin
      if (i_flush)
        for (int k = exp_q.size() - 1; k >= 0; k--)
          if (!exp_q[k].is_d && exp_q[k].due > cyc) exp_q.delete(k);
      if (gi) begin
        exp_q.push_back('{due: cyc + LAT + 1, is_d: 1'b0, data: ref_mem[i_addr[3:0]]});
        ref_last_d = 1'b0;
      end
      if (gd) begin
        if (d_we) begin
          ref_mem[d_addr[3:0]] = d_wdata;
          exp_q.push_back('{due: cyc + LAT + 1, is_d: 1'b1, data: '0});
        end else begin
          exp_q.push_back('{due: cyc + LAT + 1, is_d: 1'b1, data: ref_mem[d_addr[3:0]]});
        end
        ref_last_d = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard consumer ----------------
  logic [DW-1:0] i_hold = '0;
  logic [DW-1:0] d_hold = '0;

  always @(negedge clk) begin
    rsp_t r;
    check("one_strobe", i_valid & d_valid, 1'b0);
    if (i_valid || d_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp cycle %0d: got i_valid=%0b d_valid=%0b expected none",
                 cyc, i_valid, d_valid);
      end else begin
        r = exp_q.pop_front();
        check("rsp_port", d_valid, r.is_d);
        check("rsp_cycle", cyc, r.due);
        if (r.is_d) begin
          check("d_rdata", d_rdata, r.data);
          d_hold = r.data;
        end else begin
          check("i_rdata", i_rdata, r.data);
          i_hold = r.data;
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      r = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp cycle %0d: got no strobe expected %s response due %0d",
               cyc, r.is_d ? "d" : "i", r.due);
    end
    if (!i_valid) check("i_rdata_hold", i_rdata, i_hold);
    if (!d_valid) check("d_rdata_hold", d_rdata, d_hold);
    if (reset) begin
      i_hold = '0;
      d_hold = '0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    reset = 1'b1; i_flush = 1'b0;
    present();
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = $urandom;
      mem[k]     = ref_mem[k];
    end
    ref_mem[0] = 32'h05912000;
    mem[0]     = 32'h05912000;

    // reset held 2 cycles with both ports requesting; I wins the first tie
    push_i(32'd0);
    push_d(1'b0, 32'd5, '0);
    present();
    tick(); tick();
    reset = 1'b0;
    repeat (LAT + 4) tick();

    // single fetch of word 0
    push_i(32'd0); present();
    repeat (LAT + 3) tick();

    // store then load to the same address
    push_d(1'b1, 32'd11, 32'h38);
    push_d(1'b0, 32'd11, '0);
    present();
    repeat (LAT + 4) tick();

    // contention: alternating grants I,D,I,D,I,D
    for (int k = 1; k <= 3; k++) begin
      push_i(k);
      push_d(1'b0, k + 3, '0);
    end
    present();
    repeat (LAT + 8) tick();

    // flush kills two in-flight fetches; D load granted in the flush cycle
    push_i(32'd1); push_i(32'd2); present();
    tick(); tick();
    push_d(1'b0, 32'd7, '0);
    i_flush = 1'b1;
    present();
    tick();
    i_flush = 1'b0;
    repeat (LAT + 4) tick();

    // reset while two fetches are in flight, then a fresh fetch
    push_i(32'd3); push_i(32'd4); present();
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (LAT + 3) tick();
    push_i(32'd0); present();
    repeat (LAT + 3) tick();

    // randomized traffic
    repeat (1500) begin
      if (iq.size() < 2 && $urandom_range(0, 2) != 0)
        push_i($urandom_range(0, 15));
      if (dq.size() < 2 && $urandom_range(0, 2) != 0)
        push_d(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
      i_flush = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      present();
      tick();
    end

    // drain
    i_flush = 1'b0;
    reset   = 1'b0;
    guard   = 0;
    while ((iq.size() > 0 || dq.size() > 0) && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (iq.size() > 0 || dq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d i / %0d d requests pending expected 0",
               iq.size(), dq.size());
    end
    repeat (LAT + 3) tick();
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
